// File: rtl/issue_ctrl_pkg.sv
// Shared types for the issue controller: FSM state encoding and register-index sizing.
// Pure declarations, no logic and no flow control.
package issue_ctrl_pkg;
    localparam int REG_W = 5;
    localparam int NREGS = 1 << REG_W;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        MEM_REQ = 2'd1,
        MEM_WB  = 2'd2
    } state_t;
endpackage

// File: rtl/issue_scoreboard.sv
// Pending-write scoreboard: one bit per architectural register, with set/clear ports and three read checks.
// Read checks are combinational from the registered vector; set/clear land at the clock edge, and no backpressure exists here.
module issue_scoreboard
    import issue_ctrl_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             set_en,
    input  logic [REG_W-1:0] set_idx,
    input  logic             clr_en,
    input  logic [REG_W-1:0] clr_idx,
    input  logic [REG_W-1:0] rs1,
    input  logic [REG_W-1:0] rs2,
    input  logic [REG_W-1:0] rd,
    output logic [NREGS-1:0] pending,
    output logic             rs1_hit,
    output logic             rs2_hit,
    output logic             rd_hit
);

    logic [NREGS-1:0] pending_nxt;

    // Clear first so that a same-cycle set of the same register wins; x0 is never tracked.
    always_comb begin
        pending_nxt = pending;
        if (clr_en)
            pending_nxt[clr_idx] = 1'b0;
        if (set_en && (set_idx != '0))
            pending_nxt[set_idx] = 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            pending <= '0;
        else
            pending <= pending_nxt;
    end

    assign rs1_hit = pending[rs1];
    assign rs2_hit = pending[rs2];
    assign rd_hit  = pending[rd];

endmodule

// File: rtl/issue_ctrl.sv
// Scoreboard issue controller: hazard stalls, single-outstanding memory sequencing, and ALU/load write-port arbitration.
// ex_valid one cycle after accept, ALU wb ALU_LAT later; dec_ready drops on hazards or while the memory path is busy.
module issue_ctrl
    import issue_ctrl_pkg::*;
#(
    parameter int ALU_LAT = 1,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             dec_valid,
    output logic             dec_ready,
    input  logic [REG_W-1:0] dec_rs1,
    input  logic [REG_W-1:0] dec_rs2,
    input  logic             dec_use_rs2,
    input  logic [REG_W-1:0] dec_rd,
    input  logic             dec_reg_write,
    input  logic             dec_mem_read,
    input  logic             dec_mem_write,
    output logic             ex_valid,
    output logic             mem_req,
    output logic             mem_we,
    input  logic             mem_ack,
    output logic             wb_valid,
    output logic [REG_W-1:0] wb_rd,
    output logic             wb_from_mem,
    output logic [CNT_W-1:0] stall_cnt,
    output logic             busy
);

    state_t           state;
    logic [REG_W-1:0] ld_rd;
    logic             ld_wr;

    logic [ALU_LAT:0] alu_vld;
    logic [REG_W-1:0] alu_rd [0:ALU_LAT];

    logic [NREGS-1:0] pending;
    logic             rs1_hit, rs2_hit, rd_hit;

    logic mem_op, hazard, block, accept, wr_any;
    logic alu_wr, ld_set, alu_wb, ld_ack, mem_wb;

    assign mem_op    = dec_mem_read | dec_mem_write;
    assign hazard    = rs1_hit | (dec_use_rs2 & rs2_hit) | (dec_reg_write & rd_hit);
    assign block     = (state == MEM_WB) | (mem_op & (state != IDLE));
    assign dec_ready = !hazard && !block;
    assign accept    = dec_valid & dec_ready;
    assign wr_any    = dec_reg_write & (dec_rd != '0);

    assign alu_wr = accept & wr_any & !mem_op;
    assign ld_set = accept & wr_any & dec_mem_read & !dec_mem_write;

    // ALU results own the write port; load data waits (in MEM_WB) for a free cycle.
    assign alu_wb = alu_vld[ALU_LAT];
    assign ld_ack = (state == MEM_REQ) & mem_ack;
    assign mem_wb = !alu_wb & ((ld_ack & ld_wr) | (state == MEM_WB));

    assign wb_valid    = alu_wb | mem_wb;
    assign wb_rd       = alu_wb ? alu_rd[ALU_LAT] : ld_rd;
    assign wb_from_mem = mem_wb;
    assign busy        = (|pending) | (|alu_vld) | (state != IDLE);

    issue_scoreboard u_sb (
        .clk     (clk),
        .rst     (rst),
        .set_en  (alu_wr | ld_set),
        .set_idx (dec_rd),
        .clr_en  (wb_valid),
        .clr_idx (wb_rd),
        .rs1     (dec_rs1),
        .rs2     (dec_rs2),
        .rd      (dec_rd),
        .pending (pending),
        .rs1_hit (rs1_hit),
        .rs2_hit (rs2_hit),
        .rd_hit  (rd_hit)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            mem_req <= 1'b0;
            mem_we  <= 1'b0;
            ld_rd   <= '0;
            ld_wr   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept && mem_op) begin
                        state   <= MEM_REQ;
                        mem_req <= 1'b1;
                        mem_we  <= dec_mem_write;
                        ld_rd   <= dec_rd;
                        ld_wr   <= dec_mem_read & !dec_mem_write & wr_any;
                    end
                end
                MEM_REQ: begin
                    if (mem_ack) begin
                        mem_req <= 1'b0;
                        mem_we  <= 1'b0;
                        state   <= (ld_wr && alu_wb) ? MEM_WB : IDLE;
                    end
                end
                MEM_WB: begin
                    if (!alu_wb)
                        state <= IDLE;
                end
                default: begin
                    state   <= IDLE;
                    mem_req <= 1'b0;
                    mem_we  <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ex_valid  <= 1'b0;
            alu_vld   <= '0;
            stall_cnt <= '0;
            for (int i = 0; i <= ALU_LAT; i++)
                alu_rd[i] <= '0;
        end else begin
            ex_valid   <= accept;
            alu_vld[0] <= alu_wr;
            alu_rd[0]  <= dec_rd;
            for (int i = 1; i <= ALU_LAT; i++) begin
                alu_vld[i] <= alu_vld[i-1];
                alu_rd[i]  <= alu_rd[i-1];
            end
            if (dec_valid && !dec_ready && (stall_cnt != '1))
                stall_cnt <= stall_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_issue_ctrl.sv
// Bench for issue_ctrl: directed scenarios plus random traffic, every cycle compared with a transaction-level model.
module tb_issue_ctrl;
    localparam int ALU_LAT = 1;
    localparam int CNT_W   = 4;
    localparam int STALL_MAX = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst;
    logic             dec_valid, dec_ready;
    logic [4:0]       dec_rs1, dec_rs2, dec_rd;
    logic             dec_use_rs2, dec_reg_write, dec_mem_read, dec_mem_write;
    logic             ex_valid, mem_req, mem_we, mem_ack;
    logic             wb_valid, wb_from_mem, busy;
    logic [4:0]       wb_rd;
    logic [CNT_W-1:0] stall_cnt;

    issue_ctrl #(.ALU_LAT(ALU_LAT), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst),
        .dec_valid(dec_valid), .dec_ready(dec_ready),
        .dec_rs1(dec_rs1), .dec_rs2(dec_rs2), .dec_use_rs2(dec_use_rs2),
        .dec_rd(dec_rd), .dec_reg_write(dec_reg_write),
        .dec_mem_read(dec_mem_read), .dec_mem_write(dec_mem_write),
        .ex_valid(ex_valid), .mem_req(mem_req), .mem_we(mem_we), .mem_ack(mem_ack),
        .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_from_mem(wb_from_mem),
        .stall_cnt(stall_cnt), .busy(busy)
    );

    always #5 clk = ~clk;

    // Reference model: architectural register reservations, scheduled ALU completions,
    // and the one outstanding memory transaction (0 none, 1 awaiting ack, 2 data waiting for the port).
    bit pend [32];
    int cyc;
    int alu_due [$];
    int alu_rdq [$];
    int mphase;
    bit m_store, m_wr;
    int m_rd;
    bit exp_ex;
    int exp_stall;

    int n_pass, n_total;
    bit acc;
    int n;
    bit obs_rdy, obs_wbv, obs_fm, obs_ex;
    logic [4:0] obs_wbrd;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic model_reset();
        foreach (pend[i]) pend[i] = 1'b0;
        alu_due.delete();
        alu_rdq.delete();
        mphase = 0; m_store = 0; m_wr = 0; m_rd = 0;
        exp_ex = 0; exp_stall = 0; cyc = 0;
    endtask

    task automatic drive_idle();
        dec_valid = 0; dec_rs1 = 0; dec_rs2 = 0; dec_use_rs2 = 0; dec_rd = 0;
        dec_reg_write = 0; dec_mem_read = 0; dec_mem_write = 0; mem_ack = 0;
    endtask

    task automatic do_reset();
        drive_idle();
        rst = 1'b1;
        #2;
        rst = 1'b0;
        model_reset();
        @(negedge clk);
    endtask

    // One cycle: drive at the negedge, compare mid-low-phase, advance the model, wait for next negedge.
    task automatic step(input bit v, input logic [4:0] a, input logic [4:0] b, input bit u2,
                        input logic [4:0] d, input bit rw, input bit mr, input bit mw,
                        input bit ack, output bit accepted);
        bit alu_now, mem_now, e_wbv, e_fm, haz, blk, rdy, anyp, e_busy;
        int e_rd;
        dec_valid = v; dec_rs1 = a; dec_rs2 = b; dec_use_rs2 = u2; dec_rd = d;
        dec_reg_write = rw; dec_mem_read = mr; dec_mem_write = mw; mem_ack = ack;
        #1;
        alu_now = (alu_due.size() > 0) && (alu_due[0] == cyc);
        mem_now = (mphase == 1 && ack && m_wr) || (mphase == 2);
        e_wbv   = alu_now || mem_now;
        e_rd    = alu_now ? alu_rdq[0] : m_rd;
        e_fm    = !alu_now && mem_now;
        haz     = pend[a] || (u2 && pend[b]) || (rw && pend[d]);
        blk     = (mphase == 2) || ((mr || mw) && mphase != 0);
        rdy     = !haz && !blk;
        anyp    = 0;
        foreach (pend[i]) anyp |= pend[i];
        e_busy  = anyp || (alu_due.size() > 0) || (mphase != 0);

        obs_rdy = dec_ready; obs_wbv = wb_valid; obs_fm = wb_from_mem;
        obs_wbrd = wb_rd; obs_ex = ex_valid;

        chk("dec_ready", dec_ready, rdy);
        chk("ex_valid", ex_valid, exp_ex);
        chk("mem_req", mem_req, mphase == 1);
        if (mphase == 1) chk("mem_we", mem_we, m_store);
        chk("wb_valid", wb_valid, e_wbv);
        if (e_wbv) begin
            chk("wb_rd", wb_rd, e_rd);
            chk("wb_from_mem", wb_from_mem, e_fm);
        end
        chk("busy", busy, e_busy);
        chk("stall_cnt", stall_cnt, exp_stall);

        if (v && !rdy && exp_stall < STALL_MAX) exp_stall++;
        if (e_wbv) pend[e_rd] = 1'b0;
        if (alu_now) begin
            void'(alu_due.pop_front());
            void'(alu_rdq.pop_front());
        end
        if (mphase == 1 && ack)
            mphase = (m_wr && alu_now) ? 2 : 0;
        else if (mphase == 2 && !alu_now)
            mphase = 0;
        accepted = v && rdy;
        exp_ex = accepted;
        if (accepted) begin
            if (rw && d != 0) pend[d] = 1'b1;
            if (mr || mw) begin
                mphase = 1; m_store = mw; m_rd = d;
                m_wr = mr && !mw && rw && (d != 0);
            end else if (rw && d != 0) begin
                alu_due.push_back(cyc + 1 + ALU_LAT);
                alu_rdq.push_back(d);
            end
        end
        cyc++;
        @(negedge clk);
    endtask

    initial begin
        n_pass = 0; n_total = 0;
        rst = 1'b1;
        drive_idle();
        model_reset();
        @(negedge clk);
        do_reset();

        // Reset state
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, acc);
        chk("reset_wb_rd", obs_wbrd, 5'd0);

        // RAW: addi x5 then add x6,x5,x5
        do_reset();
        step(1, 5'd1, 5'd0, 0, 5'd5, 1, 0, 0, 0, acc);
        chk("raw_first_acc", acc, 1);
        n = 0; acc = 0;
        for (int i = 0; i < 8 && !acc; i++) begin
            step(1, 5'd5, 5'd5, 1, 5'd6, 1, 0, 0, 0, acc);
            n++;
        end
        chk("raw_issue_cycle", n, 3);
        chk("raw_stall_cnt", stall_cnt, 2);

        // Load acked on the third mem_req cycle, no ALU traffic
        do_reset();
        step(1, 5'd1, 5'd0, 0, 5'd9, 1, 1, 0, 0, acc);
        chk("ld_acc", acc, 1);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, acc);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, acc);
        step(0, 0, 0, 0, 0, 0, 0, 0, 1, acc);
        chk("ld_wb_valid", obs_wbv, 1);
        chk("ld_wb_rd", obs_wbrd, 5'd9);
        chk("ld_wb_from_mem", obs_fm, 1);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, acc);
        chk("ld_idle_busy", busy, 0);

        // Collision: lw x7 outstanding, addi x8 completes in the ack cycle
        do_reset();
        step(1, 5'd1, 5'd0, 0, 5'd7, 1, 1, 0, 0, acc);
        step(1, 5'd1, 5'd0, 0, 5'd8, 1, 0, 0, 0, acc);
        chk("col_alu_acc", acc, 1);
        step(1, 5'd2, 5'd3, 1, 5'd0, 0, 0, 1, 0, acc);
        step(1, 5'd2, 5'd3, 1, 5'd0, 0, 0, 1, 1, acc);
        chk("col_k_rd", obs_wbrd, 5'd8);
        chk("col_k_fm", obs_fm, 0);
        chk("col_k_rdy", obs_rdy, 0);
        step(1, 5'd2, 5'd3, 1, 5'd0, 0, 0, 1, 0, acc);
        chk("col_k1_rd", obs_wbrd, 5'd7);
        chk("col_k1_fm", obs_fm, 1);
        chk("col_k1_rdy", obs_rdy, 0);
        step(1, 5'd2, 5'd3, 1, 5'd0, 0, 0, 1, 0, acc);
        chk("col_store_acc", acc, 1);
        step(0, 0, 0, 0, 0, 0, 0, 0, 1, acc);

        // Back-to-back stores
        do_reset();
        step(1, 5'd1, 5'd2, 1, 5'd0, 0, 0, 1, 0, acc);
        step(1, 5'd3, 5'd4, 1, 5'd0, 0, 0, 1, 0, acc);
        chk("st2_held", acc, 0);
        step(1, 5'd3, 5'd4, 1, 5'd0, 0, 0, 1, 1, acc);
        chk("st2_held_ack", acc, 0);
        chk("st_no_wb", obs_wbv, 0);
        step(1, 5'd3, 5'd4, 1, 5'd0, 0, 0, 1, 0, acc);
        chk("st2_acc", acc, 1);
        step(0, 0, 0, 0, 0, 0, 0, 0, 1, acc);
        chk("st2_no_wb", obs_wbv, 0);

        // Writes to x0
        do_reset();
        step(1, 5'd1, 5'd0, 0, 5'd0, 1, 0, 0, 0, acc);
        step(1, 5'd0, 5'd0, 1, 5'd2, 1, 0, 0, 0, acc);
        chk("x0_ex_valid", obs_ex, 1);
        chk("x0_next_acc", acc, 1);
        chk("x0_no_wb", obs_wbv, 0);

        // Random traffic, registers drawn from a small pool to provoke hazards
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            bit v, u2, rw, mr, mw, ack;
            logic [4:0] a, b, d;
            int op;
            v  = ($urandom % 10) < 7;
            op = $urandom % 4;
            a  = 5'($urandom % 8);
            b  = 5'($urandom % 8);
            d  = 5'($urandom % 8);
            mr = (op == 2);
            mw = (op == 3);
            rw = (op != 3);
            u2 = (op == 0) || (op == 3);
            ack = ($urandom % 3) == 0;
            step(v, a, b, u2, d, rw, mr, mw, ack, acc);
        end

        // Reset while a load is outstanding
        do_reset();
        step(1, 5'd1, 5'd0, 0, 5'd4, 1, 1, 0, 0, acc);
        step(1, 5'd2, 5'd0, 0, 5'd4, 1, 0, 0, 0, acc);
        chk("rst_pre_req", obs_wbv, 0);
        chk("rst_mid_req_before", mem_req, 1);
        rst = 1'b1;
        #1;
        chk("rst_mem_req", mem_req, 0);
        chk("rst_busy", busy, 0);
        chk("rst_stall", stall_cnt, 0);
        chk("rst_ex_valid", ex_valid, 0);
        #1;
        rst = 1'b0;
        drive_idle();
        model_reset();
        @(negedge clk);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, acc);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end
endmodule
